// File: rtl/aidc_lite_code_split_pkg.sv
// Shared constants for the decompressor-side bit unpacker.
// Block geometry (8 x 64-bit words, 2-bit prefix) and FSM encodings.
// Helper for the number of payload bits each fetched word contributes.
package aidc_lite_pkg;

  localparam int BLK_BITS    = 512;
  localparam int WORD_BITS   = 64;
  localparam int NUM_WORDS   = 8;
  localparam int PREFIX_BITS = 2;

  // FSM encoding kept as plain constants so older tools and netlists see stable values
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD0 = 2'd1;
  localparam state_t ST_RUN   = 2'd2;

  // Payload bits a word adds to the buffer: word 0 loses its prefix
  function automatic int word_fill_bits(input logic first_word);
    return first_word ? (WORD_BITS - PREFIX_BITS) : WORD_BITS;
  endfunction

endpackage

// File: rtl/aidc_lite_code_split_if.sv
// Bundles the block-buffer read port and the decoder window port of the unpacker.
// master = unpacker side (issues reads, presents windows).
// slave  = environment side (block buffer + downstream decoder).
interface aidc_lite_code_split_if #(
  parameter int DATA_SIZE = 66
);

  // block control
  logic                 start_i;
  logic                 done_o;
  logic                 fail_o;
  // block-buffer read port
  logic                 rd_en_o;
  logic [2:0]           rd_addr_o;
  logic [63:0]          rd_data_i;
  // decoder window port
  logic                 valid_o;
  logic [1:0]           prefix_o;
  logic [DATA_SIZE-1:0] data_o;
  logic                 consume_i;
  logic [6:0]           size_i;
  logic                 eop_i;

  modport master (
    input  start_i, rd_data_i, consume_i, size_i, eop_i,
    output done_o, fail_o, rd_en_o, rd_addr_o, valid_o, prefix_o, data_o
  );

  modport slave (
    output start_i, rd_data_i, consume_i, size_i, eop_i,
    input  done_o, fail_o, rd_en_o, rd_addr_o, valid_o, prefix_o, data_o
  );

endinterface

// File: rtl/aidc_lite_code_split_bit_merge.sv
// Shift out consumed bits and append a fetched word right below the surviving bits.
// Purely combinational; caller guarantees shift <= buf_cnt and no overflow.
// Buffer is MSB-aligned: valid bits occupy the top buf_cnt positions, rest are zero.
module aidc_lite_bit_merge
  import aidc_lite_pkg::*;
#(
  parameter int BIT_BUF_SIZE = 192,
  parameter int CNT_W        = 8
) (
  input  logic [BIT_BUF_SIZE-1:0] buf_in,
  input  logic [CNT_W-1:0]        buf_cnt,
  input  logic [6:0]              shift,
  input  logic                    word_vld,
  input  logic                    strip_prefix,
  input  logic [WORD_BITS-1:0]    word,
  output logic [BIT_BUF_SIZE-1:0] buf_out,
  output logic [CNT_W-1:0]        cnt_out
);

  logic [CNT_W-1:0]        rem;
  logic [WORD_BITS-1:0]    word_al;
  logic [BIT_BUF_SIZE-1:0] word_ext;

  // Drop consumed bits from the top, then splice the new word just below what is left
  always_comb begin
    rem      = buf_cnt - CNT_W'(shift);
    word_al  = strip_prefix ? {word[WORD_BITS-PREFIX_BITS-1:0], {PREFIX_BITS{1'b0}}} : word;
    word_ext = {word_al, {(BIT_BUF_SIZE-WORD_BITS){1'b0}}};
    buf_out  = buf_in << shift;
    cnt_out  = rem;
    if (word_vld) begin
      buf_out = buf_out | (word_ext >> rem);
      cnt_out = rem + CNT_W'(word_fill_bits(strip_prefix));
    end
  end

endmodule

// File: rtl/aidc_lite_code_split.sv
// Bit unpacker: fetches one 512-bit block as 8 words, strips the 2-bit prefix and
// presents an MSB-aligned code window; first window 4 cycles after start.
// Reads are throttled so the buffer never overflows; decoder pacing via consume/size.
module aidc_lite_code_split
  import aidc_lite_pkg::*;
#(
  parameter int DATA_SIZE    = 66,
  parameter int BIT_BUF_SIZE = 192
) (
  input  logic                   clk,
  input  logic                   rst,
  aidc_lite_code_split_if.master bus
);

  localparam int CNT_W  = $clog2(BIT_BUF_SIZE + 1);
  localparam int NEED_W = CNT_W + 2;

  state_t                  state;
  logic                    rd_en_q;
  logic [2:0]              rd_addr_q;
  logic [3:0]              words_issued;
  logic [3:0]              words_rcvd;
  logic                    ret_q;        // rd_data_i carries a wanted word this cycle
  logic [BIT_BUF_SIZE-1:0] bit_buf;
  logic [CNT_W-1:0]        buf_cnt;
  logic [9:0]              bits_used;
  logic [1:0]              prefix_q;
  logic                    done_q;
  logic                    fail_q;

  logic                    valid;
  logic                    take;
  logic                    err;
  logic                    eop_ok;
  logic                    adv;
  logic                    ending;
  logic                    issue;
  logic [10:0]             used_sum;
  logic [NEED_W-1:0]       need;
  logic [6:0]              shift;
  logic [BIT_BUF_SIZE-1:0] buf_nx;
  logic [CNT_W-1:0]        cnt_nx;
  logic [DATA_SIZE-1:0]    data_mask;

  aidc_lite_bit_merge #(
    .BIT_BUF_SIZE (BIT_BUF_SIZE),
    .CNT_W        (CNT_W)
  ) u_merge (
    .buf_in       (bit_buf),
    .buf_cnt      (buf_cnt),
    .shift        (shift),
    .word_vld     (ret_q),
    .strip_prefix (words_rcvd == 4'd0),
    .word         (bus.rd_data_i),
    .buf_out      (buf_nx),
    .cnt_out      (cnt_nx)
  );

  // Window qualification, consume legality and read throttling for this cycle
  always_comb begin
    valid    = (state == ST_RUN) &&
               ((buf_cnt >= CNT_W'(DATA_SIZE)) ||
                ((words_rcvd == 4'(NUM_WORDS)) && (buf_cnt != '0)));
    // start_i overrides any simultaneous consume
    take     = bus.consume_i && valid && !bus.start_i;
    used_sum = {1'b0, bits_used} + {4'b0, bus.size_i};
    err      = take && ((bus.size_i == 7'd0) ||
                        (CNT_W'(bus.size_i) > buf_cnt) ||
                        (used_sum > 11'(BLK_BITS)));
    eop_ok   = take && !err && bus.eop_i;
    adv      = take && !err;
    ending   = err || eop_ok;
    shift    = adv ? bus.size_i : 7'd0;
    // room check counts the read already on the bus plus the one being considered
    need     = {2'b0, cnt_nx} + (rd_en_q ? NEED_W'(WORD_BITS) : '0) + NEED_W'(WORD_BITS);
    issue    = (state != ST_IDLE) && !ending && !bus.start_i &&
               (words_issued < 4'(NUM_WORDS)) && (need <= NEED_W'(BIT_BUF_SIZE));
  end

  // Zero any window bits that lie past the valid part of the buffer
  always_comb begin
    data_mask = ~({DATA_SIZE{1'b1}} >> buf_cnt);
  end

  // Block sequencing: start/abort, read issue, buffer update, completion and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= 3'd0;
      words_issued <= 4'd0;
      words_rcvd   <= 4'd0;
      ret_q        <= 1'b0;
      bit_buf      <= '0;
      buf_cnt      <= '0;
      bits_used    <= 10'd0;
      prefix_q     <= 2'b00;
      done_q       <= 1'b1;
      fail_q       <= 1'b0;
    end else if (bus.start_i) begin
      // a return landing next cycle belongs to the aborted block, so ret_q is cleared
      state        <= ST_LOAD0;
      rd_en_q      <= 1'b1;
      rd_addr_q    <= 3'd0;
      words_issued <= 4'd1;
      words_rcvd   <= 4'd0;
      ret_q        <= 1'b0;
      bit_buf      <= '0;
      buf_cnt      <= '0;
      bits_used    <= 10'(PREFIX_BITS);
      prefix_q     <= 2'b00;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      rd_en_q <= issue;
      ret_q   <= rd_en_q && !ending;
      if (issue) begin
        rd_addr_q    <= words_issued[2:0];
        words_issued <= words_issued + 4'd1;
      end
      if (err) begin
        fail_q <= 1'b1;
        done_q <= 1'b1;
        state  <= ST_IDLE;
      end else if (eop_ok) begin
        done_q    <= 1'b1;
        bits_used <= used_sum[9:0];
        state     <= ST_IDLE;
      end else if (state != ST_IDLE) begin
        bit_buf <= buf_nx;
        buf_cnt <= cnt_nx;
        if (adv) begin
          bits_used <= used_sum[9:0];
        end
        if (ret_q) begin
          words_rcvd <= words_rcvd + 4'd1;
          if (words_rcvd == 4'd0) begin
            prefix_q <= bus.rd_data_i[WORD_BITS-1 -: PREFIX_BITS];
          end
          if (state == ST_LOAD0) begin
            state <= ST_RUN;
          end
        end
      end
    end
  end

  assign bus.rd_en_o   = rd_en_q;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.valid_o   = valid;
  assign bus.prefix_o  = prefix_q;
  assign bus.data_o    = bit_buf[BIT_BUF_SIZE-1 -: DATA_SIZE] & data_mask;
  assign bus.done_o    = done_q;
  assign bus.fail_o    = fail_q;

endmodule

// File: tb/tb_aidc_lite_code_split.sv
// Self-checking bench for the bit unpacker: random blocks, block-level reference model.
// Expected windows come from the 512-bit block image indexed by a consumed-bit pointer.
// Block buffer responds one cycle after each read request.
`timescale 1ns/1ps
module tb_aidc_lite_code_split;
  import aidc_lite_pkg::*;

  localparam int DS = 66;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aidc_lite_code_split_if #(.DATA_SIZE(DS)) bus ();

  aidc_lite_code_split #(.DATA_SIZE(DS), .BIT_BUF_SIZE(192)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [511:0] blk;          // block image, bit 511 = first bit of word 0
  logic [63:0]  mem [0:7];
  int           rd_log [$];
  int           buf_over = 0;

  // block buffer: data one cycle after request, garbage otherwise
  always @(posedge clk) bus.rd_data_i <= bus.rd_en_o ? mem[bus.rd_addr_o] : {$urandom, $urandom};

  // record issued read addresses just after each edge
  always @(posedge clk) begin
    #1;
    if (bus.rd_en_o === 1'b1) rd_log.push_back(int'(bus.rd_addr_o));
  end

  always @(negedge clk) if (dut.buf_cnt > 192) buf_over++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [DS-1:0] exp_win(input int pos);
    logic [DS-1:0] w;
    w = '0;
    for (int j = 0; j < DS; j++) if (pos + j < 512) w[DS-1-j] = blk[511-pos-j];
    return w;
  endfunction

  task automatic load_mem();
    for (int k = 0; k < 8; k++) mem[k] = blk[511-64*k -: 64];
  endtask

  task automatic rand_blk();
    for (int k = 0; k < 16; k++) blk[511-32*k -: 32] = $urandom;
    load_mem();
  endtask

  task automatic put_bits(input int pos, input int n, input logic [DS-1:0] v);
    for (int j = 0; j < n; j++) blk[511-pos-j] = v[n-1-j];
  endtask

  task automatic do_start();
    @(negedge clk); bus.start_i = 1'b1;
    @(negedge clk); bus.start_i = 1'b0;
  endtask

  // called at a negedge; waits (bounded) for valid_o, captures window, consumes one cycle
  task automatic consume_one(input int sz, input bit eop, output logic [DS-1:0] win, output bit got);
    got = 1'b0; win = '0;
    for (int i = 0; i < 64; i++) begin
      if (bus.valid_o === 1'b1) begin
        win = bus.data_o;
        bus.consume_i = 1'b1; bus.size_i = 7'(sz); bus.eop_i = eop;
        @(negedge clk);
        bus.consume_i = 1'b0; bus.eop_i = 1'b0; bus.size_i = 7'd0;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.rd_en_o !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", bus.rd_en_o); else n_pass++;
    n_chk++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid_o); else n_pass++;
    n_chk++; if (bus.done_o !== 1'b1) $display("FAIL reset_done: got %b want 1", bus.done_o); else n_pass++;
    n_chk++; if (bus.fail_o !== 1'b0) $display("FAIL reset_fail: got %b want 0", bus.fail_o); else n_pass++;
    n_chk++; if (bus.prefix_o !== 2'b00) $display("FAIL reset_prefix: got %b want 00", bus.prefix_o); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [DS-1:0] code [3];
    int            sz [3];
    logic [DS-1:0] win;
    bit            got;
    int            pos;
    sz[0] = 6; sz[1] = 34; sz[2] = 34;
    code[0] = DS'($urandom_range(0, 63));
    code[1] = {32'b0, 2'($urandom_range(0, 3)), 32'($urandom)};
    code[2] = {32'b0, 2'($urandom_range(0, 3)), 32'($urandom)};
    blk = '0;
    put_bits(0, 2, DS'(2'b01));
    put_bits(2, 6, code[0]);
    put_bits(8, 34, code[1]);
    put_bits(42, 34, code[2]);
    load_mem();
    rd_log.delete();
    do_start();  // now in T+1
    n_chk++; if (bus.rd_en_o !== 1'b1 || bus.rd_addr_o !== 3'd0) $display("FAIL basic_rd0: got en=%b addr=%0d want en=1 addr=0", bus.rd_en_o, bus.rd_addr_o); else n_pass++;
    n_chk++; if (bus.done_o !== 1'b0) $display("FAIL basic_done_clr: got %b want 0", bus.done_o); else n_pass++;
    @(negedge clk);  // T+2
    n_chk++; if (bus.rd_en_o !== 1'b1 || bus.rd_addr_o !== 3'd1) $display("FAIL basic_rd1: got en=%b addr=%0d want en=1 addr=1", bus.rd_en_o, bus.rd_addr_o); else n_pass++;
    @(negedge clk);  // T+3
    n_chk++; if (bus.prefix_o !== 2'b01) $display("FAIL basic_prefix: got %b want 01", bus.prefix_o); else n_pass++;
    n_chk++; if (bus.valid_o !== 1'b0) $display("FAIL basic_valid_t3: got %b want 0", bus.valid_o); else n_pass++;
    // consume while not valid must be ignored
    bus.consume_i = 1'b1; bus.size_i = 7'd6;
    @(negedge clk);  // T+4
    bus.consume_i = 1'b0; bus.size_i = 7'd0;
    n_chk++; if (bus.valid_o !== 1'b1) $display("FAIL basic_valid_t4: got %b want 1", bus.valid_o); else n_pass++;
    n_chk++; if (bus.fail_o !== 1'b0) $display("FAIL basic_ignored_consume: fail got %b want 0", bus.fail_o); else n_pass++;
    pos = 2;
    for (int c = 0; c < 3; c++) begin
      consume_one(sz[c], 1'b0, win, got);
      n_chk++; if (!got || (win >> (DS - sz[c])) !== code[c]) $display("FAIL basic_code%0d: got %h want %h", c, win >> (DS - sz[c]), code[c]); else n_pass++;
      n_chk++; if (win !== exp_win(pos)) $display("FAIL basic_win%0d: got %h want %h", c, win, exp_win(pos)); else n_pass++;
      pos += sz[c];
    end
    n_chk++;
    if (rd_log.size() < 3 || rd_log[0] != 0 || rd_log[1] != 1 || rd_log[2] != 2)
      $display("FAIL basic_addr_seq: got %0d reads first=%p want 0,1,2", rd_log.size(), rd_log);
    else n_pass++;
  endtask

  task automatic test_full_block();
    logic [DS-1:0] win;
    bit            got;
    int            pos;
    bit            seq_ok;
    rand_blk();
    rd_log.delete();
    do_start();
    pos = 2;
    for (int c = 0; c < 15; c++) begin
      consume_one(34, c == 14, win, got);
      n_chk++; if (!got || win !== exp_win(pos)) $display("FAIL full_win%0d: got %h want %h", c, win, exp_win(pos)); else n_pass++;
      pos += 34;
    end
    n_chk++; if (bus.done_o !== 1'b1 || bus.fail_o !== 1'b0) $display("FAIL full_end: got done=%b fail=%b want done=1 fail=0", bus.done_o, bus.fail_o); else n_pass++;
    n_chk++; if (bus.valid_o !== 1'b0) $display("FAIL full_valid_after: got %b want 0", bus.valid_o); else n_pass++;
    repeat (4) @(negedge clk);
    seq_ok = (rd_log.size() == 8);
    for (int i = 0; i < rd_log.size() && i < 8; i++) if (rd_log[i] != i) seq_ok = 1'b0;
    n_chk++; if (seq_ok !== 1'b1) $display("FAIL full_reads: got %0d reads %p want 0..7", rd_log.size(), rd_log); else n_pass++;
  endtask

  task automatic test_overrun();
    logic [DS-1:0] win;
    bit            got;
    int            pos;
    rand_blk();
    do_start();
    pos = 2;
    for (int c = 0; c < 7; c++) begin
      consume_one(DS, 1'b0, win, got);
      n_chk++; if (!got || win !== exp_win(pos)) $display("FAIL ovr_win%0d: got %h want %h", c, win, exp_win(pos)); else n_pass++;
      pos += DS;
    end
    n_chk++; if (bus.fail_o !== 1'b0) $display("FAIL ovr_pre: fail got %b want 0", bus.fail_o); else n_pass++;
    consume_one(DS, 1'b0, win, got);
    n_chk++; if (!got || bus.fail_o !== 1'b1 || bus.done_o !== 1'b1) $display("FAIL ovr_cross: got fail=%b done=%b want 1 1", bus.fail_o, bus.done_o); else n_pass++;
    n_chk++; if (bus.valid_o !== 1'b0) $display("FAIL ovr_valid: got %b want 0", bus.valid_o); else n_pass++;
    // zero-length consume is a protocol error too
    rand_blk();
    do_start();
    n_chk++; if (bus.fail_o !== 1'b0) $display("FAIL zero_clr: fail got %b want 0", bus.fail_o); else n_pass++;
    consume_one(0, 1'b0, win, got);
    n_chk++; if (!got || bus.fail_o !== 1'b1 || bus.done_o !== 1'b1) $display("FAIL zero_size: got fail=%b done=%b want 1 1", bus.fail_o, bus.done_o); else n_pass++;
  endtask

  // max_rate: consume full windows whenever offered; otherwise random sizes and gaps
  task automatic test_stream(input bit max_rate, input int nblk);
    logic [DS-1:0] win;
    bit            got;
    int            pos;
    int            sz;
    int            nc;
    for (int b = 0; b < nblk; b++) begin
      rand_blk();
      do_start();
      pos = 2; nc = 0;
      while (pos < 512 && nc < 600) begin
        sz = max_rate ? DS : $urandom_range(1, DS);
        if (sz > 512 - pos) sz = 512 - pos;
        if (!max_rate) repeat ($urandom_range(0, 2)) @(negedge clk);
        consume_one(sz, (pos + sz) == 512, win, got);
        n_chk++; if (!got || win !== exp_win(pos)) $display("FAIL stream%0d_b%0d_pos%0d: got %h want %h", max_rate, b, pos, win, exp_win(pos)); else n_pass++;
        if (!got) break;
        pos += sz; nc++;
      end
      n_chk++; if (bus.done_o !== 1'b1 || bus.fail_o !== 1'b0) $display("FAIL stream%0d_end_b%0d: got done=%b fail=%b want 1 0", max_rate, b, bus.done_o, bus.fail_o); else n_pass++;
    end
    n_chk++; if (buf_over != 0) $display("FAIL stream%0d_buf_bound: got %0d over-full cycles want 0", max_rate, buf_over); else n_pass++;
  endtask

  task automatic test_abort_reset();
    logic [DS-1:0] win;
    bit            got;
    bit            found;
    int            pos;
    rand_blk();
    blk[511:510] = 2'b10;
    blk[447:446] = 2'b01;  // word 1 carries a different would-be prefix
    load_mem();
    do_start();          // T+1
    @(negedge clk);      // T+2: word 1 requested, returns next cycle
    n_chk++; if (bus.rd_en_o !== 1'b1 || bus.rd_addr_o !== 3'd1) $display("FAIL abort_inflight: got en=%b addr=%0d want 1 1", bus.rd_en_o, bus.rd_addr_o); else n_pass++;
    bus.start_i = 1'b1; rd_log.delete();
    @(negedge clk); bus.start_i = 1'b0;
    n_chk++; if (bus.rd_en_o !== 1'b1 || bus.rd_addr_o !== 3'd0) $display("FAIL abort_restart: got en=%b addr=%0d want 1 0", bus.rd_en_o, bus.rd_addr_o); else n_pass++;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.prefix_o !== 2'b10) $display("FAIL abort_prefix: got %b want 10", bus.prefix_o); else n_pass++;
    pos = 2;
    for (int c = 0; c < 2; c++) begin
      consume_one(DS, 1'b0, win, got);
      n_chk++; if (!got || win !== exp_win(pos)) $display("FAIL abort_win%0d: got %h want %h", c, win, exp_win(pos)); else n_pass++;
      pos += DS;
    end
    n_chk++; if (rd_log.size() < 1 || rd_log[0] != 0) $display("FAIL abort_addr0: got %p want first 0", rd_log); else n_pass++;
    // reset while a read is outstanding
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rd_en_o === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_chk++; if (found !== 1'b1) $display("FAIL rst_find_read: got no read in 20 cycles want one"); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (bus.rd_en_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.done_o !== 1'b1 || bus.fail_o !== 1'b0 || bus.prefix_o !== 2'b00)
      $display("FAIL rst_mid: got en=%b vld=%b done=%b fail=%b pfx=%b want 0 0 1 0 00", bus.rd_en_o, bus.valid_o, bus.done_o, bus.fail_o, bus.prefix_o);
    else n_pass++;
    @(negedge clk);
    n_chk++; if (bus.valid_o !== 1'b0 || bus.rd_en_o !== 1'b0) $display("FAIL rst_quiet: got vld=%b en=%b want 0 0", bus.valid_o, bus.rd_en_o); else n_pass++;
    rd_log.delete();
    do_start();
    repeat (2) @(negedge clk);
    n_chk++; if (bus.prefix_o !== 2'b10) $display("FAIL rst_prefix: got %b want 10", bus.prefix_o); else n_pass++;
    consume_one(DS, 1'b0, win, got);
    n_chk++; if (!got || win !== exp_win(2)) $display("FAIL rst_win: got %h want %h", win, exp_win(2)); else n_pass++;
    n_chk++; if (rd_log.size() < 2 || rd_log[0] != 0 || rd_log[1] != 1) $display("FAIL rst_addr_seq: got %p want 0,1,...", rd_log); else n_pass++;
  endtask

  initial begin
    bus.start_i   = 1'b0;
    bus.consume_i = 1'b0;
    bus.size_i    = 7'd0;
    bus.eop_i     = 1'b0;
    for (int k = 0; k < 8; k++) mem[k] = '0;
    blk = '0;
    test_reset();
    test_basic();
    test_full_block();
    test_overrun();
    test_stream(1'b1, 3);
    test_stream(1'b0, 2);
    test_abort_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
